// File: rtl/minion_bus_arbiter.sv
// minion_bus_arbiter: round-robin arbiter and sequencer sharing the 16-slot
// minion peripheral bus between master 0 (core LSU) and master 1 (debug/DMA).
//
// state  | meaning
// IDLE   | bus quiet, a pending request is granted this cycle
// ACCESS | registered ce/we strobe on the latched slot, no grant
// RESP   | owner gets rvalid/rdata/err, a pending request may be granted
module minion_bus_arbiter #(
    parameter logic [15:0] SLOT_MASK = 16'hFFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         m0_req,
    input  logic [31:0]  m0_addr,
    input  logic         m0_we,
    input  logic [3:0]   m0_be,
    input  logic [31:0]  m0_wdata,
    output logic         m0_gnt,
    output logic         m0_rvalid,
    output logic [31:0]  m0_rdata,
    output logic         m0_err,
    input  logic         m1_req,
    input  logic [31:0]  m1_addr,
    input  logic         m1_we,
    input  logic [3:0]   m1_be,
    input  logic [31:0]  m1_wdata,
    output logic         m1_gnt,
    output logic         m1_rvalid,
    output logic [31:0]  m1_rdata,
    output logic         m1_err,
    output logic [19:0]  bus_addr,
    output logic [31:0]  bus_wdata,
    output logic [3:0]   bus_be,
    output logic [15:0]  bus_ce,
    output logic [15:0]  bus_we,
    input  logic [511:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [3:0]  slot_q, slot_d;
    logic [19:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [15:0] ce_q, ce_d;
    logic [15:0] wen_q, wen_d;

    logic        accept;
    logic        win;
    logic [31:0] sel_addr;
    logic [3:0]  sel_slot;
    logic        resp;
    logic        slot_pop;
    logic [8:0]  rd_base;
    logic [31:0] rd_word;

    // Round-robin pick and the accept window; gnt is held low while in reset.
    always_comb begin
        win = 1'b0;
        if (m0_req && m1_req) begin
            win = ~last_q;
        end else if (m1_req) begin
            win = 1'b1;
        end
        accept   = (state_q == IDLE || state_q == RESP) && (m0_req || m1_req) && rst;
        m0_gnt   = accept && !win;
        m1_gnt   = accept && win;
        sel_addr = win ? m1_addr : m0_addr;
        sel_slot = sel_addr[23:20];
    end

    // Next state, payload capture at grant, and the one-hot strobes for ACCESS.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        slot_d  = slot_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        ce_d    = 16'h0000;
        wen_d   = 16'h0000;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = ACCESS;
                    owner_d = win;
                    last_d  = win;
                    we_d    = win ? m1_we : m0_we;
                    slot_d  = sel_slot;
                    addr_d  = sel_addr[19:0];
                    wdata_d = win ? m1_wdata : m0_wdata;
                    be_d    = win ? m1_be : m0_be;
                    if (SLOT_MASK[sel_slot]) begin
                        ce_d  = 16'h0001 << sel_slot;
                        wen_d = (win ? m1_we : m0_we) ? (16'h0001 << sel_slot) : 16'h0000;
                    end
                end
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // State and latched transaction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            slot_q  <= 4'h0;
            addr_q  <= 20'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            ce_q    <= 16'h0;
            wen_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            slot_q  <= slot_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ce_q    <= ce_d;
            wen_q   <= wen_d;
        end
    end

    // Response steering: read data passes straight from the selected slot.
    always_comb begin
        resp      = (state_q == RESP);
        slot_pop  = SLOT_MASK[slot_q];
        rd_base   = {slot_q, 5'd0};
        rd_word   = (resp && !we_q && slot_pop) ? bus_rdata[rd_base +: 32] : 32'h0;
        m0_rvalid = resp && !owner_q;
        m1_rvalid = resp && owner_q;
        m0_rdata  = m0_rvalid ? rd_word : 32'h0;
        m1_rdata  = m1_rvalid ? rd_word : 32'h0;
        m0_err    = m0_rvalid && !slot_pop;
        m1_err    = m1_rvalid && !slot_pop;
    end

    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;
    assign bus_ce    = ce_q;
    assign bus_we    = wen_q;

endmodule
